// File: rtl/instr_encoder.sv
// Streaming RV32I instruction encoder: packs field-level requests into 32-bit
// words and writes them sequentially into instruction memory.
module instr_encoder #(
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  restart,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [2:0]            req_class,
  input  logic [4:0]            req_rd,
  input  logic [4:0]            req_rs1,
  input  logic [4:0]            req_rs2,
  input  logic [2:0]            req_funct3,
  input  logic [6:0]            req_funct7,
  input  logic [31:0]           req_imm,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  err
);

  localparam int unsigned CNT_W = ADDR_WIDTH + 1;
  localparam logic [CNT_W-1:0] CAPACITY = CNT_W'(1) << ADDR_WIDTH;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I_ALU  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef enum logic {
    ST_LOADING,
    ST_FULL
  } state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  err_q, err_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]           mem_wdata_q, mem_wdata_d;

  logic [31:0] enc_word;
  logic        enc_legal;
  logic        fits12, fits13, fits21;
  logic        accept;

  // Signed-range checks: all bits above the field's sign bit must match it.
  assign fits12 = (&req_imm[31:11]) | ~(|req_imm[31:11]);
  assign fits13 = (&req_imm[31:12]) | ~(|req_imm[31:12]);
  assign fits21 = (&req_imm[31:20]) | ~(|req_imm[31:20]);

  always_comb begin
    enc_word  = 32'd0;
    enc_legal = 1'b1;
    case (req_class)
      3'd0: enc_word = {req_funct7, req_rs2, req_rs1, req_funct3, req_rd, OP_R};
      3'd1: begin
        enc_word  = {req_imm[11:0], req_rs1, req_funct3, req_rd, OP_I_ALU};
        enc_legal = fits12;
      end
      3'd2: begin
        enc_word  = {req_imm[11:0], req_rs1, req_funct3, req_rd, OP_LOAD};
        enc_legal = fits12;
      end
      3'd3: begin
        enc_word  = {req_imm[11:5], req_rs2, req_rs1, req_funct3, req_imm[4:0], OP_STORE};
        enc_legal = fits12;
      end
      3'd4: begin
        enc_word  = {req_imm[12], req_imm[10:5], req_rs2, req_rs1, req_funct3,
                     req_imm[4:1], req_imm[11], OP_BRANCH};
        enc_legal = fits13 & ~req_imm[0];
      end
      3'd5: begin
        enc_word  = {req_imm[20], req_imm[10:1], req_imm[11], req_imm[19:12], req_rd, OP_JAL};
        enc_legal = fits21 & ~req_imm[0];
      end
      3'd6: begin
        enc_word  = {req_imm[31:12], req_rd, OP_LUI};
        enc_legal = ~(|req_imm[11:0]);
      end
      default: begin
        enc_word  = {req_imm[11:0], req_rs1, 3'b000, req_rd, OP_JALR};
        enc_legal = fits12;
      end
    endcase
  end

  assign req_ready = (state_q != ST_FULL) & ~restart;
  assign accept    = req_valid & req_ready;

  // Next-state: restart clears the pointer and flags; accepted requests either write or flag an error.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    err_d       = err_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if (restart) begin
      state_d = ST_LOADING;
      count_d = '0;
      err_d   = 1'b0;
    end else if (accept) begin
      if (enc_legal) begin
        mem_we_d    = 1'b1;
        mem_addr_d  = count_q[ADDR_WIDTH-1:0];
        mem_wdata_d = enc_word;
        count_d     = count_q + CNT_W'(1);
        if (count_d == CAPACITY) state_d = ST_FULL;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_LOADING;
      count_q     <= '0;
      err_q       <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      err_q       <= err_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign count     = count_q;
  assign full      = (state_q == ST_FULL);
  assign err       = err_q;

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Streaming RV32I instruction encoder, the inverse of the control decode path. It accepts field-level instruction requests over a valid/ready handshake and packs them into 32-bit RV32I words. Each word is written sequentially into instruction memory through a single write port. It sits between the test/boot program source and instruction memory, and is used to preload programs for the core.

## Interface
Parameters:
- ADDR_WIDTH, 8, instruction-memory word-address width; capacity is 2^ADDR_WIDTH words.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- restart  in  1  synchronous clear of the write pointer, `full` and `err`; memory contents are untouched.
- req_valid  in  1  request present.
- req_ready  out  1  equals `!full & !restart`.
- req_class  in  3  instruction class:
  - 0 R-type
  - 1 I-ALU
  - 2 LOAD
  - 3 STORE
  - 4 BRANCH
  - 5 JAL
  - 6 LUI
  - 7 JALR
- req_rd, req_rs1, req_rs2  in  5 each  register fields.
- req_funct3  in  3; req_funct7  in  7  function fields.
- req_imm  in  32  byte-offset or immediate value, two's complement.
- mem_we  out  1  instruction-memory write strobe.
- mem_addr  out  ADDR_WIDTH  word address of the write.
- mem_wdata  out  32  encoded instruction.
- count  out  ADDR_WIDTH+1  words written since reset or restart.
- full  out  1  set when `count == 2^ADDR_WIDTH`.
- err  out  1  sticky flag: at least one request was rejected.

## Operation
Encoding by class, with fields listed MSB to LSB:
- R: funct7 | rs2 | rs1 | funct3 | rd | 0110011.
- I-ALU: imm[11:0] | rs1 | funct3 | rd | 0010011.
- LOAD: imm[11:0] | rs1 | funct3 | rd | 0000011.
- STORE: imm[11:5] | rs2 | rs1 | funct3 | imm[4:0] | 0100011.
- BRANCH: imm[12] | imm[10:5] | rs2 | rs1 | funct3 | imm[4:1] | imm[11] | 1100011.
- JAL: imm[20] | imm[10:1] | imm[11] | imm[19:12] | rd | 1101111.
- LUI: imm[31:12] | rd | 0110111.
- JALR: imm[11:0] | rs1 | 000 | rd | 1100111. req_funct3 is ignored.
- Fields not listed for a class (e.g. rs2 for I-ALU) are ignored.

Legality checks, evaluated on the request fields at acceptance:
- I-ALU, LOAD, STORE, JALR: imm[31:11] must be all-equal (fits 12-bit signed).
- BRANCH: imm[31:12] must be all-equal, and imm[0] must be 0.
- JAL: imm[31:20] must be all-equal, and imm[0] must be 0.
- LUI: imm[11:0] must be 0.
- R-type: always legal.

Request handling:
- A request is accepted on a cycle with `req_valid & req_ready`.
- A legal accepted request is registered into the write stage, and the write pointer then increments by 1.
- An illegal accepted request is consumed without a write: `err` is set, and `count` and the pointer are unchanged.

States:
- LOADING: `full` = 0.
- FULL: `full` = 1.
- LOADING → FULL occurs on the legal write that makes `count` reach 2^ADDR_WIDTH.
- FULL → LOADING occurs only on `restart` or `rst`.

Arithmetic:
- `mem_addr` is `count[ADDR_WIDTH-1:0]` captured at acceptance.
- `count` saturates at 2^ADDR_WIDTH; the pointer never wraps.

## Timing
- Reset values:
  - `mem_we`=0, `mem_addr`=0, `mem_wdata`=0.
  - `count`=0, `full`=0, `err`=0.
  - `req_ready` follows its equation, so it is 1 unless `restart` is high.
- Write latency: a request accepted at edge N produces `mem_we`=1 with its address and data during cycle N+1, i.e. at edge N+1.
- Throughput is one word per cycle for back-to-back requests.
- `count` and `full` update at the acceptance edge N, so `req_ready` drops in the cycle after the last slot is taken.
- `mem_we` is a single-cycle pulse per legal request; `mem_addr` and `mem_wdata` hold their last values when `mem_we`=0.
- Restart:
  - `restart` high forces `req_ready`=0, so no acceptance occurs that cycle. It wins over a simultaneous `req_valid`.
  - A write already in the write stage still completes in the `restart` cycle.
  - `count`, `full` and `err` read 0 from the next cycle.
- `rst` mid-stream clears the write stage: `mem_we`=0 in the cycle after the reset edge, and a pending write is dropped.
- `err` stays set across further legal writes until `restart` or `rst`.

## Test plan
- Encode checks, each sent as a single request after reset:
  - I-ALU, rd=1, rs1=0, f3=000, imm=5 → `mem_we` pulse, addr 0, data 0x00500093.
  - R-type, rd=3, rs1=1, rs2=2, f3=000, f7=0 → 0x002081B3.
- Back-to-back stream of four requests with no idle cycles:
  - STORE rs1=1, rs2=2, f3=010, imm=8 → 0x0020A423.
  - BRANCH rs1=1, rs2=2, f3=000, imm=-4 → 0xFE208EE3.
  - JAL rd=1, imm=8 → 0x008000EF.
  - LUI rd=5, imm=0x12345000 → 0x123452B7.
  - Required: addresses 0..3 on consecutive cycles, then `count`=4.
- Illegal requests:
  - I-ALU imm=2048 → no `mem_we`, `err`=1, `count` unchanged.
  - Next, BRANCH imm=3 → no write, `err` still 1.
  - Next, a legal request → written at the unchanged address, `err` remains 1.
- Full, with ADDR_WIDTH=2:
  - Five continuous valid requests → exactly four writes at addresses 0..3.
  - `full`=1 and `req_ready`=0 from the cycle after the fourth acceptance; `count`=4; the fifth request is never accepted.
- Restart racing a request:
  - From the FULL state, assert `restart` together with `req_valid` → no acceptance that cycle.
  - Next cycle: `count`=0, `full`=0, `err`=0.
  - The following request writes address 0.
- Reset mid-write: assert `rst` at the edge following an acceptance → `mem_we`=0 in the next cycle, all outputs at reset values, `count`=0.
